// File: rtl/char_buf_arb_if.sv
// char_buf_arb_if: CPU store, clear, VGA read and buffer port signals
// grouped for the character buffer scheduler.
interface char_buf_arb_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ready;
   logic              clr_start;
   logic [DATA_W-1:0] clr_data;
   logic              clr_busy;
   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt;
   logic [DATA_W-1:0] vga_rdata;
   logic              vga_rvalid;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_req, cpu_addr, cpu_wdata,
      input  clr_start, clr_data,
      input  vga_req, vga_addr, mem_rdata,
      output cpu_ready, clr_busy,
      output vga_gnt, vga_rdata, vga_rvalid,
      output mem_addr, mem_we, mem_wdata
   );

   modport master (
      output cpu_req, cpu_addr, cpu_wdata,
      output clr_start, clr_data,
      output vga_req, vga_addr, mem_rdata,
      input  cpu_ready, clr_busy,
      input  vga_gnt, vga_rdata, vga_rvalid,
      input  mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/char_buf_arb.sv
// char_buf_arb: one access per clock on the character buffer port.
// VGA reads win until a pending write has waited STARVE_MAX grants.
module char_buf_arb #(
   parameter int ADDR_W     = 12,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int CLR_LAST   = 4095,
   parameter int STARVE_MAX = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   char_buf_arb_if.slave bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [PW:0]       DEPTH_L = (PW+1)'(FIFO_DEPTH);
   localparam logic [SW-1:0]     SMAX    = SW'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] CLAST   = ADDR_W'(CLR_LAST);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            r_state, w_state_nx;
   logic [ADDR_W-1:0] r_clr_ctr, w_clr_ctr_nx;
   logic [DATA_W-1:0] r_clr_data, w_clr_data_nx;
   logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
   logic [DATA_W-1:0] r_fd [FIFO_DEPTH];
   logic [PW:0]       r_wptr, r_rptr, w_cnt;
   logic [SW-1:0]     r_starve;
   logic              r_rd_pend, r_rvalid;
   logic [DATA_W-1:0] r_rdata;
   logic              w_busy, w_empty, w_ready, w_push;
   logic              w_pend, w_vgnt, w_wgnt, w_pop;

   assign w_cnt   = r_wptr - r_rptr;
   assign w_empty = (w_cnt == '0);
   assign w_ready = !i_rst && (w_cnt != DEPTH_L);
   assign w_push  = bus.cpu_req && w_ready;
   assign w_busy  = (r_state == S_CLEAR);
   assign w_pend  = w_busy || !w_empty;
   assign w_vgnt  = !i_rst && bus.vga_req && (r_starve < SMAX);
   assign w_wgnt  = !i_rst && !w_vgnt && w_pend;
   assign w_pop   = w_wgnt && !w_busy;

   assign bus.cpu_ready  = w_ready;
   assign bus.clr_busy   = w_busy;
   assign bus.vga_gnt    = w_vgnt;
   assign bus.mem_we     = w_wgnt;
   assign bus.vga_rdata  = r_rdata;
   assign bus.vga_rvalid = r_rvalid;
   assign bus.mem_addr   = i_rst   ? '0 :
                           !w_wgnt ? bus.vga_addr :
                           w_busy  ? r_clr_ctr :
                                     r_fa[r_rptr[PW-1:0]];
   assign bus.mem_wdata  = w_busy ? r_clr_data : r_fd[r_rptr[PW-1:0]];

   // clr_start wins over the final-write exit so a restart is never lost
   always_comb begin
      w_state_nx    = r_state;
      w_clr_ctr_nx  = r_clr_ctr;
      w_clr_data_nx = r_clr_data;
      if (w_busy && w_wgnt) begin
         if (r_clr_ctr == CLAST) w_state_nx = S_IDLE;
         else w_clr_ctr_nx = r_clr_ctr + ADDR_W'(1);
      end
      if (bus.clr_start) begin
         w_state_nx    = S_CLEAR;
         w_clr_ctr_nx  = '0;
         w_clr_data_nx = bus.clr_data;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_clr_ctr  <= '0;
         r_clr_data <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_starve   <= '0;
         r_rd_pend  <= 1'b0;
         r_rvalid   <= 1'b0;
         r_rdata    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_clr_ctr  <= w_clr_ctr_nx;
         r_clr_data <= w_clr_data_nx;
         if (w_push) r_wptr <= r_wptr + (PW+1)'(1);
         if (bus.clr_start) r_rptr <= r_wptr;
         else if (w_pop) r_rptr <= r_rptr + (PW+1)'(1);
         if (!w_pend || w_wgnt) r_starve <= '0;
         else if (w_vgnt && r_starve != SMAX) r_starve <= r_starve + SW'(1);
         r_rd_pend <= w_vgnt;
         r_rvalid  <= r_rd_pend;
         if (r_rd_pend) r_rdata <= bus.mem_rdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_fa[r_wptr[PW-1:0]] <= bus.cpu_addr;
         r_fd[r_wptr[PW-1:0]] <= bus.cpu_wdata;
      end
   end
endmodule

// File: tb/tb_char_buf_arb.sv
// tb_char_buf_arb: directed scenarios plus random traffic against
// a queue-based reference of the scheduler.
module tb_char_buf_arb;
   localparam int AW = 12;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int CLAST = 4095;
   localparam int SMAX = 8;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } st_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   char_buf_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   char_buf_arb #(
      .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH),
      .CLR_LAST(CLAST), .STARVE_MAX(SMAX)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus(bus)
   );

   logic [DW-1:0] ram [2**AW];
   always @(posedge clk) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   int total = 0;
   int bad = 0;

   st_t q[$];
   bit m_clr = 0;
   int m_ctr = 0;
   logic [DW-1:0] m_cdata = '0;
   int m_starve = 0;
   bit p1 = 0, p2 = 0, k1 = 0, k2 = 0;
   logic [DW-1:0] d1, d2;
   logic [DW-1:0] ref_mem [2**AW];
   bit ref_known [2**AW];
   bit m_eg = 0, m_acc = 0;
   int clr_wr = 0, busy_cyc = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      bit pend, ew;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      #1;
      if (rst) begin
         q.delete();
         m_clr = 0; m_ctr = 0; m_starve = 0;
         p1 = 0; p2 = 0; m_eg = 0; m_acc = 0;
         chk("rst_we", bus.mem_we, 0);
         chk("rst_gnt", bus.vga_gnt, 0);
         chk("rst_rdy", bus.cpu_ready, 0);
         chk("rst_addr", bus.mem_addr, 0);
         chk("rst_busy", bus.clr_busy, 0);
         chk("rst_rv", bus.vga_rvalid, 0);
         chk("rst_rd", bus.vga_rdata, 0);
      end else begin
         pend = m_clr || (q.size() > 0);
         m_eg = bus.vga_req && (m_starve < SMAX);
         ew = !m_eg && pend;
         ea = bus.vga_addr;
         ed = '0;
         if (ew) begin
            ea = m_clr ? AW'(m_ctr) : q[0].a;
            ed = m_clr ? m_cdata : q[0].d;
         end
         chk("gnt", bus.vga_gnt, m_eg);
         chk("we", bus.mem_we, ew);
         chk("addr", bus.mem_addr, ea);
         if (ew) chk("wdata", bus.mem_wdata, ed);
         chk("ready", bus.cpu_ready, q.size() < DEPTH);
         chk("busy", bus.clr_busy, m_clr);
         chk("rvalid", bus.vga_rvalid, p2);
         if (p2 && k2) chk("rdata", bus.vga_rdata, d2);
         if (bus.mem_we && bus.clr_busy) clr_wr++;
         if (bus.clr_busy) busy_cyc++;
         m_acc = bus.cpu_req && (q.size() < DEPTH);
         if (ew) begin
            ref_mem[ea] = ed;
            ref_known[ea] = 1;
         end
         p2 = p1; d2 = d1; k2 = k1;
         p1 = m_eg;
         d1 = ref_mem[bus.vga_addr];
         k1 = ref_known[bus.vga_addr];
         if (!pend || ew) m_starve = 0;
         else if (m_eg) m_starve = (m_starve + 1 > SMAX) ? SMAX : m_starve + 1;
         if (ew && m_clr) begin
            if (m_ctr == CLAST) m_clr = 0;
            else m_ctr++;
         end else if (ew) begin
            void'(q.pop_front());
         end
         if (bus.clr_start) begin
            q.delete();
            m_clr = 1; m_ctr = 0; m_cdata = bus.clr_data;
         end
         if (m_acc) q.push_back('{bus.cpu_addr, bus.cpu_wdata});
      end
      @(negedge clk);
   endtask

   initial begin
      int idx;
      int guard;
      bus.cpu_req = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.clr_start = 0; bus.clr_data = '0;
      bus.vga_req = 0; bus.vga_addr = '0;
      @(negedge clk);
      step(); step();
      rst = 0;
      step();

      // three stores on an idle port
      for (int i = 0; i < 3; i++) begin
         bus.cpu_req = 1;
         bus.cpu_addr = AW'(5 + i);
         bus.cpu_wdata = 32'h0FF00041 + DW'(i);
         step();
      end
      bus.cpu_req = 0;
      repeat (4) step();

      // one queued store under continuous VGA reads
      bus.vga_req = 1; bus.vga_addr = 12'h005;
      bus.cpu_req = 1; bus.cpu_addr = 12'h010; bus.cpu_wdata = 32'h11;
      step();
      bus.cpu_req = 0;
      repeat (20) step();

      // five stores against a nearly blocked port
      idx = 0;
      for (int c = 0; c < 60; c++) begin
         bus.cpu_req = (idx < 5);
         bus.cpu_addr = AW'(12'h020 + idx);
         bus.cpu_wdata = DW'(32'h100 + idx);
         step();
         if (m_acc) idx++;
      end
      chk("five_acc", idx, 5);
      bus.cpu_req = 0; bus.vga_req = 0;
      repeat (10) step();

      // clear with two stores queued behind VGA traffic
      bus.vga_req = 1; bus.vga_addr = 12'h006;
      for (int i = 0; i < 2; i++) begin
         bus.cpu_req = 1;
         bus.cpu_addr = AW'(12'h040 + i);
         bus.cpu_wdata = 32'hDEAD0000 + DW'(i);
         step();
      end
      bus.cpu_req = 0;
      bus.clr_start = 1; bus.clr_data = 32'h00000020;
      clr_wr = 0; busy_cyc = 0;
      step();
      bus.clr_start = 0; bus.vga_req = 0;
      guard = 0;
      while (m_clr && guard < 5000) begin
         bus.cpu_req = (guard == 2000);
         bus.cpu_addr = 12'h777; bus.cpu_wdata = 32'h12345678;
         step();
         guard++;
      end
      bus.cpu_req = 0;
      chk("clr_writes", clr_wr, 4096);
      chk("clr_cycles", busy_cyc, 4096);
      repeat (3) step();
      chk("post_clr_ram", ram[12'h777], 32'h12345678);

      // store then read 0x123
      bus.cpu_req = 1; bus.cpu_addr = 12'h123; bus.cpu_wdata = 32'hABCD1234;
      step();
      bus.cpu_req = 0;
      step();
      bus.vga_req = 1; bus.vga_addr = 12'h123;
      step();
      bus.vga_req = 0;
      step();
      chk("rd123_valid", bus.vga_rvalid, 1);
      chk("rd123_data", bus.vga_rdata, 32'hABCD1234);
      repeat (2) step();

      // reset in the middle of a clear with a read in flight
      bus.clr_start = 1; bus.clr_data = $urandom;
      step();
      bus.clr_start = 0;
      guard = 0;
      while (m_ctr != 100 && guard < 300) begin
         step();
         guard++;
      end
      chk("ctr_reach", m_ctr, 100);
      bus.vga_req = 1; bus.vga_addr = 12'h123;
      step();
      bus.vga_req = 0;
      rst = 1;
      step(); step();
      rst = 0;
      step(); step();
      chk("rel_rdy", bus.cpu_ready, 1);

      // random traffic
      for (int c = 0; c < 6000; c++) begin
         if (!bus.vga_req || m_eg) begin
            bus.vga_req = ($urandom_range(0, 99) < 60);
            bus.vga_addr = AW'($urandom);
         end
         if (!bus.cpu_req || m_acc) begin
            bus.cpu_req = ($urandom_range(0, 99) < 30);
            bus.cpu_addr = AW'($urandom);
            bus.cpu_wdata = $urandom;
         end
         bus.clr_start = ($urandom_range(0, 2999) == 0);
         bus.clr_data = $urandom;
         step();
      end
      bus.clr_start = 0; bus.vga_req = 0; bus.cpu_req = 0;
      repeat (5) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
